// File: rtl/mdu_ctrl_pkg.sv
// Shared HI/LO unit definitions: MD op encodings, default latencies, sizing helper.
// Used by the decode stage and by mdu_ctrl / mdu_arith.
package mdu_ctrl_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  localparam int MDU_MULT_LAT = 5;
  localparam int MDU_DIV_LAT  = 10;

  // Counter width able to hold the larger of the two latencies.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational product / quotient for the HI/LO unit.
// Divide logic is present only when MDU_DIV_EN is defined.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo,
  output logic              o_dz
);

  logic signed [2*DATA_W-1:0] w_a_sx;
  logic signed [2*DATA_W-1:0] w_b_sx;
  logic signed [2*DATA_W-1:0] w_prod_s;
  logic        [2*DATA_W-1:0] w_prod_u;

  assign w_a_sx   = {{DATA_W{i_a[DATA_W-1]}}, i_a};
  assign w_b_sx   = {{DATA_W{i_b[DATA_W-1]}}, i_b};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};

`ifdef MDU_DIV_EN
  logic signed [DATA_W-1:0] w_a_s;
  logic signed [DATA_W-1:0] w_bsafe_s;
  logic        [DATA_W-1:0] w_bsafe_u;
  logic signed [DATA_W-1:0] w_q_s;
  logic signed [DATA_W-1:0] w_r_s;
  logic        [DATA_W-1:0] w_q_u;
  logic        [DATA_W-1:0] w_r_u;
  logic                     w_bz;
  logic                     w_ovf;

  assign w_bz  = (i_b == '0);
  // MIN/-1 overflows; dividing by +1 instead yields the wrapped MIN quotient and zero remainder.
  assign w_ovf = (i_a == {1'b1, {(DATA_W-1){1'b0}}}) && (i_b == '1);

  assign w_a_s     = i_a;
  assign w_bsafe_s = (w_bz || w_ovf) ? DATA_W'(1) : i_b;
  assign w_bsafe_u = w_bz ? DATA_W'(1) : i_b;
  assign w_q_s     = w_a_s / w_bsafe_s;
  assign w_r_s     = w_a_s % w_bsafe_s;
  assign w_q_u     = i_a / w_bsafe_u;
  assign w_r_u     = i_a % w_bsafe_u;
`endif

  always_comb begin
    o_hi = w_prod_s[2*DATA_W-1:DATA_W];
    o_lo = w_prod_s[DATA_W-1:0];
    o_dz = 1'b0;
    case (i_op)
      MD_MULTU: begin
        o_hi = w_prod_u[2*DATA_W-1:DATA_W];
        o_lo = w_prod_u[DATA_W-1:0];
      end
`ifdef MDU_DIV_EN
      MD_DIV: begin
        o_hi = w_r_s;
        o_lo = w_q_s;
        o_dz = w_bz;
      end
      MD_DIVU: begin
        o_hi = w_r_u;
        o_lo = w_q_u;
        o_dz = w_bz;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide controller: IDLE/BUSY FSM, latency counter, temp and HI/LO registers.
// Define MDU_DIV_EN to enable DIV/DIVU; otherwise they behave as NONE.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MDU_MULT_LAT,
  parameter int DIV_LAT  = MDU_DIV_LAT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        e_md_op,
  input  logic [DATA_W-1:0] e_rs_val,
  input  logic [DATA_W-1:0] e_rt_val,
  input  logic              d_md_use,
  output logic              start,
  output logic              busy,
  output logic              stall,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = cnt_width(MULT_LAT, DIV_LAT);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);

  logic [0:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_tmp_hi;
  logic [DATA_W-1:0] r_tmp_lo;
  logic              r_tmp_we;

  logic              w_idle;
  logic              w_is_mul;
  logic              w_is_div;
  logic [CNT_W-1:0]  w_lat;
  logic [DATA_W-1:0] w_res_hi;
  logic [DATA_W-1:0] w_res_lo;
  logic              w_dz;

  assign w_idle   = (r_state == S_IDLE);
  assign w_is_mul = (e_md_op == MD_MULT) || (e_md_op == MD_MULTU);

`ifdef MDU_DIV_EN
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
  assign w_is_div = (e_md_op == MD_DIV) || (e_md_op == MD_DIVU);
  assign w_lat    = w_is_div ? DIV_CNT : MULT_CNT;
`else
  assign w_is_div = 1'b0;
  assign w_lat    = MULT_CNT;
`endif

  assign start = w_idle && (w_is_mul || w_is_div);
  assign busy  = (r_state == S_BUSY);
  assign stall = d_md_use && (start || busy);
  assign hi    = r_hi;
  assign lo    = r_lo;

  mdu_arith u_arith (
    .i_op (e_md_op),
    .i_a  (e_rs_val),
    .i_b  (e_rt_val),
    .o_hi (w_res_hi),
    .o_lo (w_res_lo),
    .o_dz (w_dz)
  );

  // Result is parked in temp registers at start and only reaches HI/LO on the final busy edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_tmp_hi <= '0;
      r_tmp_lo <= '0;
      r_tmp_we <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_tmp_hi <= w_res_hi;
            r_tmp_lo <= w_res_lo;
            r_tmp_we <= !(w_is_div && w_dz);
            r_cnt    <= w_lat;
            r_state  <= S_BUSY;
          end else if (e_md_op == MD_MTHI) begin
            r_hi <= e_rs_val;
          end else if (e_md_op == MD_MTLO) begin
            r_lo <= e_rs_val;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_IDLE;
            if (r_tmp_we) begin
              r_hi <= r_tmp_hi;
              r_lo <= r_tmp_lo;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized scoreboard bench for mdu_ctrl; honours MDU_DIV_EN the same way as the design.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
`ifdef MDU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  e_md_op = MD_NONE;
  logic [31:0] e_rs_val = '0;
  logic [31:0] e_rt_val = '0;
  logic        d_md_use = 1'b0;
  logic        start, busy, stall;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .e_md_op  (e_md_op),
    .e_rs_val (e_rs_val),
    .e_rt_val (e_rt_val),
    .d_md_use (d_md_use),
    .start    (start),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op in E at posedge+1; returns at posedge+1 after the op has fully retired.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dmd);
    bit is_mul, is_div, is_md;
    int lat, n;
    logic [31:0] pre_hi, pre_lo;
    longint sq, sr;
    is_mul = (op == MD_MULT) || (op == MD_MULTU);
    is_div = DIV_ON && ((op == MD_DIV) || (op == MD_DIVU));
    is_md  = is_mul || is_div;
    lat    = is_div ? DIV_LAT : MULT_LAT;
    pre_hi = m_hi;
    pre_lo = m_lo;
    case (op)
      MD_MULT:  begin sq = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = sq; end
      MD_MULTU: {m_hi, m_lo} = {32'b0, a} * {32'b0, b};
      MD_DIV: if (DIV_ON && b != 0) begin
        sq = longint'($signed(a)) / longint'($signed(b));
        sr = longint'($signed(a)) % longint'($signed(b));
        m_lo = sq[31:0];
        m_hi = sr[31:0];
      end
      MD_DIVU: if (DIV_ON && b != 0) begin m_lo = a / b; m_hi = a % b; end
      MD_MTHI: m_hi = a;
      MD_MTLO: m_lo = a;
      default: ;
    endcase
    if (is_md || op == MD_MTHI || op == MD_MTLO) exp_q.push_back({m_hi, m_lo});
    e_md_op = op; e_rs_val = a; e_rt_val = b; d_md_use = dmd;
    #1;
    chk("start", start, is_md);
    chk("stall_e", stall, dmd && is_md);
    @(posedge clk); #1;
    e_md_op = MD_NONE; e_rs_val = $urandom; e_rt_val = $urandom;
    if (is_md) begin
      n = 0;
      for (int k = 0; k < MULT_LAT + DIV_LAT + 4; k++) begin
        @(negedge clk);
        if (!busy) break;
        n++;
        chk("stall_busy", stall, dmd);
        chk("hold", {hi, lo}, {pre_hi, pre_lo});
        #2;
        if (n < lat) begin
          e_md_op = 4'($urandom_range(1, 6));
          #1;
          chk("start_busy", start, 1'b0);
        end else begin
          e_md_op = MD_NONE;
        end
      end
      chk("busy_len", 64'(n), 64'(lat));
      chk("stall_after", stall, 1'b0);
    end else begin
      @(negedge clk);
      chk("no_busy", busy, 1'b0);
      if (op != MD_MTHI && op != MD_MTLO) chk("unchanged", {hi, lo}, {m_hi, m_lo});
    end
    @(posedge clk); #1;
    d_md_use = 1'b0;
  endtask

  // Monitor: captures pre-edge state, then checks HI/LO whenever a commit or MT write lands.
  initial begin
    bit c_busy, c_mt, c_rst;
    logic [63:0] e;
    c_busy = 0; c_mt = 0; c_rst = 0;
    forever begin
      @(negedge clk);
      if (c_rst && reset_n && ((c_busy && !busy) || c_mt)) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", {hi, lo}, 64'hx);
        end else begin
          e = exp_q.pop_front();
          chk(c_mt ? "sb_mt" : "sb_commit", {hi, lo}, e);
        end
      end
      #4;
      c_rst  = reset_n;
      c_busy = busy;
      c_mt   = ((e_md_op == MD_MTHI) || (e_md_op == MD_MTLO)) && !busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", start, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_hilo", {hi, lo}, 64'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult_dir", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("multu_dir", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_dir", {hi, lo}, DIV_ON ? 64'hFFFF_FFFF_FFFF_FFFD : 64'h0000_0001_FFFF_FFFE);
    run_op(MD_DIVU, 32'd5, 32'd0, 1'b0);
    chk("divz_dir", {hi, lo}, DIV_ON ? 64'hFFFF_FFFF_FFFF_FFFD : 64'h0000_0001_FFFF_FFFE);
    run_op(MD_MULT, 32'd6, 32'd7, 1'b1);
    chk("mult_stall_dir", {hi, lo}, 64'h0000_0000_0000_002A);
    run_op(MD_MTHI, 32'h1234_5678, 32'd0, 1'b1);
    chk("mthi_dir", hi, 32'h1234_5678);
    run_op(MD_MFLO, 32'd1, 32'd1, 1'b1);

    // Abort a multiply in its third busy cycle.
    e_md_op = MD_MULT; e_rs_val = 32'd7; e_rt_val = 32'd9;
    @(posedge clk); #1;
    e_md_op = MD_NONE;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_hilo", {hi, lo}, 64'h0);
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (MULT_LAT + 3) @(negedge clk);
    chk("abort_no_commit", {hi, lo}, 64'h0);
    chk("abort_idle", busy, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("first_edge_start", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 8));
      a = pick();
      b = pick();
      if ($urandom_range(0, 5) == 0) b = 32'h0;
      run_op(op, a, b, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_LAT, default 5: busy cycles for mult/multu.
REQ-002 Parameter DIV_LAT, default 10: busy cycles for div/divu.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 e_md_op  input  4  E-stage HI/LO operation code: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
REQ-006 e_rs_val  input  32  forwarded rs operand in E.
REQ-007 e_rt_val  input  32  forwarded rt operand in E.
REQ-008 d_md_use  input  1  D-stage instruction is any HI/LO op, including mf/mt.
REQ-009 start  output  1  E-stage op is MULT/MULTU/DIV/DIVU in this cycle.
REQ-010 busy  output  1  a multiply/divide is in flight.
REQ-011 stall  output  1  freeze F/D and insert an E bubble.
REQ-012 hi  output  32  architectural HI.
REQ-013 lo  output  32  architectural LO.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE and BUSY.
REQ-015 start SHALL be combinational and SHALL assert only when e_md_op is MULT/MULTU/DIV/DIVU and the state is IDLE.
REQ-016 On the start edge, the block SHALL capture the result into internal temp registers, load the counter with MULT_LAT or DIV_LAT, and enter BUSY.
REQ-017 busy SHALL be high for exactly LAT cycles after the start edge.
REQ-018 The counter SHALL decrement each cycle in BUSY.
REQ-019 On the edge where the counter goes from 1 to 0, hi/lo SHALL load the temp registers and the FSM SHALL return to IDLE; hi/lo SHALL NOT change earlier.
REQ-020 MULT/MULTU SHALL write {hi,lo} as the signed or unsigned 64-bit product.
REQ-021 DIV/DIVU SHALL write lo as the quotient and hi as the remainder, signed or unsigned, truncating toward zero.
REQ-022 Divide by zero SHALL still take DIV_LAT busy cycles and SHALL leave hi/lo unchanged.
REQ-023 MTHI/MTLO SHALL write e_rs_val to hi/lo at the next edge, only in IDLE.
REQ-024 MFHI/MFLO SHALL NOT change state; the datapath reads hi/lo directly.
REQ-025 stall SHALL equal d_md_use AND (start OR busy).
REQ-026 A start in the final busy cycle is impossible because of REQ-025; if an MD op is nevertheless in E while busy, the block SHALL ignore it.
REQ-027 The block SHALL NOT support back-to-back pipelining of operations.

Reset
REQ-028 Asserting reset_n low SHALL immediately force IDLE, counter=0, hi=0, lo=0, temp registers=0, busy=0.
REQ-029 Reset SHALL abort an in-flight operation, and its result SHALL never commit.
REQ-030 On the first rising edge after reset_n deasserts, the block SHALL accept a start.

Configuration
REQ-031 The macro MDU_DIV_EN SHALL control divide support.
REQ-032 With MDU_DIV_EN defined, DIV/DIVU SHALL behave as specified above.
REQ-033 Without MDU_DIV_EN, DIV/DIVU SHALL be treated as NONE: no start, no busy, no hi/lo change. The divider logic SHALL be absent and DIV_LAT SHALL be unused.

Structure
REQ-034 The MD op encodings and the default latencies SHALL be defined in the shared definitions header used by the pipeline decode.
REQ-035 The combinational product and quotient logic SHALL reside in one sub-module, mdu_arith, instantiated once.
REQ-036 The FSM, counter, hi/lo and temp registers SHALL reside in mdu_ctrl.

Verification
REQ-037 MULT with rs=0xFFFFFFFE, rt=3 -> start for 1 cycle; busy for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-038 MULTU with rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles; hi/lo unchanged during busy.
REQ-039 DIV with rs=-7, rt=2 -> busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with rt=0 -> 10 busy cycles; hi/lo unchanged.
REQ-040 MFLO in D while busy -> stall high every busy cycle, low the cycle after busy falls; MFLO in D with MULT in E -> stall high in the start cycle.
REQ-041 MTHI with rs=0x12345678 in IDLE -> hi=0x12345678 next edge, no stall.
REQ-042 MULT started, reset_n pulsed low in the 3rd busy cycle -> busy=0, hi=lo=0 immediately; no later commit.
